red_pitaya_daisy_link_ctrl: RTL and testbench

Autonomous bring-up sequencer for the daisy-chain link. It drives the daisy module's enable, training, test-clear and TX data-select controls in order. It judges training lock and the PRBS test result, retries on failure, and hands the lane to working data once the link is qualified. It sits in the sys_clk domain beside the daisy block and replaces manual register poking for link bring-up.

---
 rtl/red_pitaya_daisy_pkg.sv | 47 ++++
 rtl/red_pitaya_daisy_lock_det.sv | 56 +++++
 rtl/red_pitaya_daisy_link_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_red_pitaya_daisy_link_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/red_pitaya_daisy_pkg.sv
// Shared types for the daisy-chain link bring-up sequencer: state encodings,
// TX data-select codes and the per-state control bundle.
package red_pitaya_daisy_pkg;

   // FAIL and the loss-of-lock marker share 3'b111 on state_o; the marker only
   // appears while the FSM is in LINK_UP, so the two cannot be confused.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ENABLE  = 3'd1,
      ST_TRAIN   = 3'd2,
      ST_TST_CLR = 3'd3,
      ST_TEST    = 3'd4,
      ST_LINK_UP = 3'd5,
      ST_RETRY   = 3'd6,
      ST_FAIL    = 3'd7
   } state_e;

   localparam logic [2:0] STATE_LOS = 3'b111;

   localparam logic [2:0] SEL_OFF   = 3'd0;
   localparam logic [2:0] SEL_WORK  = 3'd1;
   localparam logic [2:0] SEL_TRAIN = 3'd3;
   localparam logic [2:0] SEL_TEST  = 3'd5;

   typedef struct packed {
      logic       tx_en;
      logic       rx_en;
      logic       rx_train;
      logic       tst_clr;
      logic [2:0] tx_sel;
   } ctrl_t;

   function automatic ctrl_t ctrl_for(state_e st);
      ctrl_t c;
      c = '{tx_en: 1'b0, rx_en: 1'b0, rx_train: 1'b0, tst_clr: 1'b0, tx_sel: SEL_OFF};
      case (st)
         ST_ENABLE:  c = '{tx_en: 1'b1, rx_en: 1'b1, rx_train: 1'b0, tst_clr: 1'b0, tx_sel: SEL_OFF};
         ST_TRAIN:   c = '{tx_en: 1'b1, rx_en: 1'b1, rx_train: 1'b1, tst_clr: 1'b0, tx_sel: SEL_TRAIN};
         ST_TST_CLR: c = '{tx_en: 1'b1, rx_en: 1'b1, rx_train: 1'b0, tst_clr: 1'b1, tx_sel: SEL_TEST};
         ST_TEST:    c = '{tx_en: 1'b1, rx_en: 1'b1, rx_train: 1'b0, tst_clr: 1'b0, tx_sel: SEL_TEST};
         ST_LINK_UP: c = '{tx_en: 1'b1, rx_en: 1'b1, rx_train: 1'b0, tst_clr: 1'b0, tx_sel: SEL_WORK};
         default:    c = '{tx_en: 1'b0, rx_en: 1'b0, rx_train: 1'b0, tst_clr: 1'b0, tx_sel: SEL_OFF};
      endcase
      return c;
   endfunction

endpackage

// File: rtl/red_pitaya_daisy_lock_det.sv
// RX training lock qualifier: 2-FF synchronizer for the RX-domain lock flag,
// a saturating run counter declaring lock after LOCK_CYC consecutive highs,
// and a loss detector flagging two or more consecutive synchronized lows.
module red_pitaya_daisy_lock_det #(
   parameter int unsigned LOCK_CYC = 16
) (
   input  logic clk_i,
   input  logic rstn_i,
   input  logic rx_trained_i,
   output logic lock_ok_o,
   output logic los_o
);

   localparam int unsigned CW = (LOCK_CYC < 1) ? 1 : $clog2(LOCK_CYC + 1);
   localparam logic [CW-1:0] RUN_MAX = CW'(LOCK_CYC);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic [CW-1:0] run_q, run_d;
   logic [1:0]    low_q, low_d;

   // Synchronizer chain plus high-run and low-run counters.
   always_comb begin
      sync1_d = rx_trained_i;
      sync2_d = sync1_q;
      run_d   = run_q;
      low_d   = low_q;
      if (!sync2_q)
         run_d = '0;
      else if (run_q != RUN_MAX)
         run_d = run_q + 1'b1;
      if (sync2_q)
         low_d = '0;
      else if (low_q != 2'd2)
         low_d = low_q + 2'd1;
   end

   // State flops, cleared asynchronously.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         run_q   <= '0;
         low_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         run_q   <= run_d;
         low_q   <= low_d;
      end
   end

   assign lock_ok_o = (run_q == RUN_MAX);
   assign los_o     = (low_q == 2'd2);

endmodule

// File: rtl/red_pitaya_daisy_link_ctrl.sv
// Daisy-chain link bring-up sequencer.
// Optional build macro DAISY_LINK_RETRAIN_EN: when defined, loss of lock in
// LINK_UP sends the FSM through RETRY; when undefined, LINK_UP holds and the
// loss event is reported as state_o = 3'b111 for one cycle.
//
// state   | meaning
// IDLE    | everything off, waiting for start_i
// ENABLE  | TX/RX enabled, settling for SETTLE_CYC cycles
// TRAIN   | training pattern, waiting for qualified lock or TRAIN_TMO
// TST_CLR | clearing test statistics, 4 cycles
// TEST    | PRBS test window until TEST_LEN words or TEST_TMO
// LINK_UP | working data selected, link qualified
// RETRY   | one-cycle bookkeeping of a failed attempt
// FAIL    | retries exhausted, sticky fail until start_i/stop_i
module red_pitaya_daisy_link_ctrl
   import red_pitaya_daisy_pkg::*;
#(
   parameter int unsigned SETTLE_CYC = 256,
   parameter int unsigned TRAIN_TMO  = 65536,
   parameter int unsigned LOCK_CYC   = 16,
   parameter int unsigned TEST_LEN   = 4096,
   parameter int unsigned TEST_TMO   = 1048576,
   parameter int unsigned MAX_ERR    = 0,
   parameter int unsigned MAX_RETRY  = 3
) (
   input  logic        sys_clk_i,
   input  logic        sys_rstn_i,
   input  logic        start_i,
   input  logic        stop_i,
   input  logic        rx_trained_i,
   input  logic [31:0] tst_err_cnt_i,
   input  logic [31:0] tst_dat_cnt_i,
   output logic        tx_en_o,
   output logic        rx_en_o,
   output logic        rx_train_o,
   output logic        tst_clr_o,
   output logic [2:0]  tx_sel_o,
   output logic        link_up_o,
   output logic        fail_o,
   output logic [2:0]  state_o,
   output logic [3:0]  retry_cnt_o
);

   localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYC - 1);
   localparam logic [31:0] TRAIN_LAST  = 32'(TRAIN_TMO - 1);
   localparam logic [31:0] TEST_LAST   = 32'(TEST_TMO - 1);
   localparam logic [31:0] TST_CLR_LAST = 32'd3;
   localparam logic [31:0] TEST_LEN32  = 32'(TEST_LEN);
   localparam logic [31:0] MAX_ERR32   = 32'(MAX_ERR);
   localparam logic [3:0]  MAX_RETRY4  = 4'(MAX_RETRY);

   state_e      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [3:0]  retry_q, retry_d;
   ctrl_t       ctrl_q, ctrl_d;
   logic        link_up_q, link_up_d;
   logic        fail_q, fail_d;
   logic [2:0]  state_out_q, state_out_d;
   logic        lock_ok;
   logic        los;

   red_pitaya_daisy_lock_det #(
      .LOCK_CYC (LOCK_CYC)
   ) u_lock_det (
      .clk_i        (sys_clk_i),
      .rstn_i       (sys_rstn_i),
      .rx_trained_i (rx_trained_i),
      .lock_ok_o    (lock_ok),
      .los_o        (los)
   );

   // State register with retry bookkeeping.
   always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
      if (!sys_rstn_i) begin
         state_q <= ST_IDLE;
         retry_q <= '0;
      end else begin
         state_q <= state_d;
         retry_q <= retry_d;
      end
   end

   // Next state: stop beats timeouts, timeouts beat success.
   always_comb begin
      state_d = state_q;
      retry_d = retry_q;
      if (stop_i) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE, ST_FAIL: begin
               if (start_i) begin
                  state_d = ST_ENABLE;
                  retry_d = '0;
               end
            end
            ST_ENABLE: begin
               if (cnt_q == SETTLE_LAST) state_d = ST_TRAIN;
            end
            ST_TRAIN: begin
               if (cnt_q == TRAIN_LAST) state_d = ST_RETRY;
               else if (lock_ok)        state_d = ST_TST_CLR;
            end
            ST_TST_CLR: begin
               if (cnt_q == TST_CLR_LAST) state_d = ST_TEST;
            end
            ST_TEST: begin
               if (cnt_q == TEST_LAST)
                  state_d = ST_RETRY;
               else if (tst_dat_cnt_i >= TEST_LEN32)
                  state_d = (tst_err_cnt_i <= MAX_ERR32) ? ST_LINK_UP : ST_RETRY;
            end
            ST_LINK_UP: begin
`ifdef DAISY_LINK_RETRAIN_EN
               if (los) state_d = ST_RETRY;
`endif
            end
            ST_RETRY: begin
               if (retry_q == MAX_RETRY4) begin
                  state_d = ST_FAIL;
               end else begin
                  retry_d = retry_q + 4'd1;
                  state_d = ST_ENABLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Cycle counter: restarts on each state entry, saturates at all-ones.
   always_comb begin
      if (state_d != state_q)
         cnt_d = '0;
      else if (&cnt_q)
         cnt_d = cnt_q;
      else
         cnt_d = cnt_q + 32'd1;
   end

   // Cycle counter register.
   always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
      if (!sys_rstn_i) cnt_q <= '0;
      else             cnt_q <= cnt_d;
   end

`ifndef DAISY_LINK_RETRAIN_EN
   logic los_q, los_d;

   // Loss flag held while lock stays lost in LINK_UP; its rising edge marks one event.
   always_comb begin
      los_d = (state_q == ST_LINK_UP) && los;
   end

   // Loss flag register.
   always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
      if (!sys_rstn_i) los_q <= 1'b0;
      else             los_q <= los_d;
   end
`endif

   // Output decode from the current state; registered below, so outputs lag one cycle.
   always_comb begin
      ctrl_d      = ctrl_for(state_q);
      link_up_d   = (state_q == ST_LINK_UP);
      fail_d      = (state_q == ST_FAIL);
      state_out_d = state_q;
`ifndef DAISY_LINK_RETRAIN_EN
      if (los_d && !los_q) state_out_d = STATE_LOS;
`endif
   end

   // Output registers; reset drops every enable at once.
   always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
      if (!sys_rstn_i) begin
         ctrl_q      <= '0;
         link_up_q   <= 1'b0;
         fail_q      <= 1'b0;
         state_out_q <= '0;
      end else begin
         ctrl_q      <= ctrl_d;
         link_up_q   <= link_up_d;
         fail_q      <= fail_d;
         state_out_q <= state_out_d;
      end
   end

   assign tx_en_o     = ctrl_q.tx_en;
   assign rx_en_o     = ctrl_q.rx_en;
   assign rx_train_o  = ctrl_q.rx_train;
   assign tst_clr_o   = ctrl_q.tst_clr;
   assign tx_sel_o    = ctrl_q.tx_sel;
   assign link_up_o   = link_up_q;
   assign fail_o      = fail_q;
   assign state_o     = state_out_q;
   assign retry_cnt_o = retry_q;

endmodule

// File: tb/tb_red_pitaya_daisy_link_ctrl.sv
// Directed bench for the daisy link sequencer with short parameters.
module tb_red_pitaya_daisy_link_ctrl;

   logic        clk;
   logic        rst_n;
   logic        start, stop, trained;
   logic [31:0] err_cnt, dat_cnt;
   logic        tx_en_o, rx_en_o, rx_train_o, tst_clr_o, link_up_o, fail_o;
   logic [2:0]  tx_sel_o, state_o;
   logic [3:0]  retry_cnt_o;
   logic [15:0] obs;

   int n_vec  = 0;
   int n_miss = 0;

   red_pitaya_daisy_link_ctrl #(
      .SETTLE_CYC (8),
      .TRAIN_TMO  (32),
      .LOCK_CYC   (4),
      .TEST_LEN   (16),
      .TEST_TMO   (64),
      .MAX_ERR    (0),
      .MAX_RETRY  (2)
   ) dut (
      .sys_clk_i     (clk),
      .sys_rstn_i    (rst_n),
      .start_i       (start),
      .stop_i        (stop),
      .rx_trained_i  (trained),
      .tst_err_cnt_i (err_cnt),
      .tst_dat_cnt_i (dat_cnt),
      .tx_en_o       (tx_en_o),
      .rx_en_o       (rx_en_o),
      .rx_train_o    (rx_train_o),
      .tst_clr_o     (tst_clr_o),
      .tx_sel_o      (tx_sel_o),
      .link_up_o     (link_up_o),
      .fail_o        (fail_o),
      .state_o       (state_o),
      .retry_cnt_o   (retry_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {state, sel, tx_en, rx_en, rx_train, tst_clr, link_up, fail, retry}
   assign obs = {state_o, tx_sel_o, tx_en_o, rx_en_o, rx_train_o, tst_clr_o,
                 link_up_o, fail_o, retry_cnt_o};

   typedef struct {
      logic        start;
      logic        stop;
      logic        trained;
      logic [31:0] dat;
      logic [31:0] err;
      int          cyc;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic st, input logic sp, input logic tr,
                               input logic [31:0] dat, input int cyc,
                               input logic [2:0] s, input logic [2:0] sel,
                               input logic txen, input logic trn, input logic clr,
                               input logic link, input logic fl, input logic [3:0] rty);
      vec_t v;
      v.start   = st;
      v.stop    = sp;
      v.trained = tr;
      v.dat     = dat;
      v.err     = 32'd0;
      v.cyc     = cyc;
      v.exp     = {s, sel, txen, txen, trn, clr, link, fl, rty};
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      tick();
      tick();
   endtask

   task automatic wait_state(input logic [2:0] s, input int budget, input string nm);
      int n;
      n = 0;
      while (state_o != s && n < budget) begin
         tick();
         n++;
      end
      check(nm, {29'd0, state_o}, {29'd0, s});
   endtask

   initial begin
      int n, clr_n, en_hi, tr_hi, n_en;
      logic [3:0] max_rty;
      logic prev_en, early, saw_clr, saw_retry, saw_link;

      rst_n = 1'b0; start = 1'b0; stop = 1'b0; trained = 1'b0;
      err_cnt = '0; dat_cnt = '0;

      // Happy path then loss of lock; one row per sample point
      vecs.push_back(mk(1, 0, 0, 32'd0,  1, 3'd0, 3'd0, 0, 0, 0, 0, 0, 4'd0));
      vecs.push_back(mk(0, 0, 0, 32'd0,  1, 3'd1, 3'd0, 1, 0, 0, 0, 0, 4'd0));
      vecs.push_back(mk(0, 0, 0, 32'd0,  8, 3'd2, 3'd3, 1, 1, 0, 0, 0, 4'd0));
      vecs.push_back(mk(0, 0, 1, 32'd0,  7, 3'd2, 3'd3, 1, 1, 0, 0, 0, 4'd0));
      vecs.push_back(mk(0, 0, 1, 32'd0,  1, 3'd3, 3'd5, 1, 0, 1, 0, 0, 4'd0));
      vecs.push_back(mk(0, 0, 1, 32'd0,  3, 3'd3, 3'd5, 1, 0, 1, 0, 0, 4'd0));
      vecs.push_back(mk(0, 0, 1, 32'd0,  1, 3'd4, 3'd5, 1, 0, 0, 0, 0, 4'd0));
      vecs.push_back(mk(0, 0, 1, 32'd16, 1, 3'd4, 3'd5, 1, 0, 0, 0, 0, 4'd0));
      vecs.push_back(mk(0, 0, 1, 32'd16, 1, 3'd5, 3'd1, 1, 0, 0, 1, 0, 4'd0));
      vecs.push_back(mk(0, 0, 0, 32'd16, 4, 3'd5, 3'd1, 1, 0, 0, 1, 0, 4'd0));
`ifdef DAISY_LINK_RETRAIN_EN
      vecs.push_back(mk(0, 0, 0, 32'd0,  1, 3'd5, 3'd1, 1, 0, 0, 1, 0, 4'd0));
      vecs.push_back(mk(0, 0, 0, 32'd0,  1, 3'd6, 3'd0, 0, 0, 0, 0, 0, 4'd1));
      vecs.push_back(mk(0, 0, 0, 32'd0,  1, 3'd1, 3'd0, 1, 0, 0, 0, 0, 4'd1));
      vecs.push_back(mk(0, 1, 0, 32'd0,  1, 3'd1, 3'd0, 1, 0, 0, 0, 0, 4'd1));
      vecs.push_back(mk(0, 0, 0, 32'd0,  1, 3'd0, 3'd0, 0, 0, 0, 0, 0, 4'd1));
`else
      vecs.push_back(mk(0, 0, 0, 32'd0,  1, 3'd7, 3'd1, 1, 0, 0, 1, 0, 4'd0));
      vecs.push_back(mk(0, 0, 0, 32'd0,  1, 3'd5, 3'd1, 1, 0, 0, 1, 0, 4'd0));
      vecs.push_back(mk(0, 0, 0, 32'd0,  1, 3'd5, 3'd1, 1, 0, 0, 1, 0, 4'd0));
      vecs.push_back(mk(0, 1, 0, 32'd0,  1, 3'd5, 3'd1, 1, 0, 0, 1, 0, 4'd0));
      vecs.push_back(mk(0, 0, 0, 32'd0,  1, 3'd0, 3'd0, 0, 0, 0, 0, 0, 4'd0));
`endif

      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", {16'd0, obs}, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      tick();

      foreach (vecs[i]) begin
         start   = vecs[i].start;
         stop    = vecs[i].stop;
         trained = vecs[i].trained;
         dat_cnt = vecs[i].dat;
         err_cnt = vecs[i].err;
         repeat (vecs[i].cyc) tick();
         start = 1'b0;
         stop  = 1'b0;
         check($sformatf("vec%0d", i), {16'd0, obs}, {16'd0, vecs[i].exp});
      end

      // Training timeout: three attempts, then FAIL
      trained = 1'b0; dat_cnt = '0; err_cnt = '0;
      pulse_start();
      n_en = 0; en_hi = 0; tr_hi = 0; max_rty = '0; prev_en = 1'b0;
      for (int i = 0; i < 400 && !fail_o; i++) begin
         tick();
         if (tx_en_o && !prev_en) n_en++;
         prev_en = tx_en_o;
         if (retry_cnt_o > max_rty) max_rty = retry_cnt_o;
         if (n_en == 1 && rx_train_o) tr_hi++;
         if (n_en == 1 && tx_en_o && tx_sel_o == 3'd0) en_hi++;
      end
      check("tmo_fail", {31'd0, fail_o}, 32'd1);
      check("tmo_attempts", n_en, 32'd3);
      check("tmo_max_retry", {28'd0, max_rty}, 32'd2);
      check("settle_len", en_hi, 32'd8);
      check("train_len", tr_hi, 32'd32);
      check("fail_outputs", {16'd0, obs}, {16'd0, 3'd7, 3'd0, 6'b000001, 4'd2});
      pulse_start();
      tick();
      check("restart_from_fail", {29'd0, fail_o, tx_en_o, |retry_cnt_o}, 32'b010);
      pulse_stop();

      // Test errors on first attempt, clean second attempt with a ramp
      trained = 1'b1;
      pulse_start();
      wait_state(3'd4, 100, "reach_test1");
      dat_cnt = 32'd16; err_cnt = 32'd1;
      wait_state(3'd6, 10, "err_retry");
      check("err_retry_cnt", {28'd0, retry_cnt_o}, 32'd1);
      dat_cnt = '0; err_cnt = '0;
      n = 0; clr_n = 0;
      while (state_o != 3'd4 && n < 60) begin
         tick();
         n++;
         if (tst_clr_o) clr_n++;
      end
      check("reach_test2", {29'd0, state_o}, 32'd4);
      check("tst_clr_len", clr_n, 32'd4);
      early = 1'b0;
      for (int d = 1; d <= 16; d++) begin
         dat_cnt = 32'(d);
         tick();
         if (link_up_o) early = 1'b1;
      end
      check("no_early_link", {31'd0, early}, 32'd0);
      tick();
      check("link_after_retry", {16'd0, obs}, {16'd0, 3'd5, 3'd1, 6'b110010, 4'd1});
      pulse_stop();

      // Glitchy lock never qualifies; TRAIN times out
      dat_cnt = '0;
      trained = 1'b0;
      repeat (4) tick();
      saw_clr = 1'b0; saw_retry = 1'b0;
      for (int i = 0; i < 60; i++) begin
         trained = ((i % 4) != 3);
         start = (i == 0);
         tick();
         if (tst_clr_o) saw_clr = 1'b1;
         if (state_o == 3'd6) saw_retry = 1'b1;
      end
      start = 1'b0;
      check("glitch_no_lock", {31'd0, saw_clr}, 32'd0);
      check("glitch_timeout", {31'd0, saw_retry}, 32'd1);
      pulse_stop();

      // stop on the same cycle as test success
      trained = 1'b1; dat_cnt = '0; err_cnt = '0;
      repeat (6) tick();
      pulse_start();
      wait_state(3'd4, 100, "reach_test3");
      dat_cnt = 32'd16;
      stop = 1'b1;
      tick();
      stop = 1'b0;
      saw_link = 1'b0;
      repeat (4) begin
         tick();
         if (link_up_o) saw_link = 1'b1;
      end
      check("stop_beats_success", {31'd0, saw_link}, 32'd0);
      check("stop_idle", {29'd0, state_o}, 32'd0);

      // Asynchronous reset in TRAIN
      trained = 1'b0; dat_cnt = '0;
      pulse_start();
      wait_state(3'd2, 50, "reach_train");
      rst_n = 1'b0;
      #1;
      check("async_reset_now", {16'd0, obs}, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      tick();
      tick();
      check("post_reset_idle", {16'd0, obs}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
